// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO hub: default address map, LFSR seed/taps,
// generation-counter wrap value and the default dot FIFO entry layout.
package mmio_pkg;

  localparam int RNG_ADDR_DEF = 99;
  localparam int GEN_ADDR_DEF = 98;
  localparam int DOT_BASE_DEF = 100;

  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [13:0] GEN_WRAP = 14'd9999;

  localparam int DOT_ID_W  = 9;
  localparam int DOT_LOC_W = 32;

  typedef struct packed {
    logic                 is_y;
    logic [DOT_ID_W-1:0]  id;
    logic [DOT_LOC_W-1:0] loc;
  } dot_entry_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/dot_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever not empty.
// Pointers carry one extra wrap bit to tell full from empty.
module dot_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  T            mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop on a full FIFO frees the slot being written in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_hub.sv
// Processor MMIO decode: LFSR random read, generation counter, dot FIFO toward VGA, RAM pass-through.
// The LFSR and its address decode exist only when MMIO_HUB_RNG_EN is defined.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int NUM_DOTS   = 450,
  parameter int DOT_BASE   = DOT_BASE_DEF,
  parameter int RNG_ADDR   = RNG_ADDR_DEF,
  parameter int GEN_ADDR   = GEN_ADDR_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           proc_addr,
  input  logic [DATA_W-1:0]           proc_wdata,
  input  logic                        proc_wren,
  output logic [DATA_W-1:0]           proc_rdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic                        ram_wren,
  output logic                        dot_valid,
  input  logic                        dot_ready,
  output logic                        dot_is_y,
  output logic [$clog2(NUM_DOTS)-1:0] dot_id,
  output logic [DATA_W-1:0]           dot_loc,
  output logic [13:0]                 gen_count,
  output logic                        fifo_ovf
);
  localparam int ID_W = $clog2(NUM_DOTS);

  typedef struct packed {
    logic              is_y;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] loc;
  } entry_t;

  logic [31:0] addr_w;
  logic        sel_rng, sel_gen, sel_dot, sel_ram, in_dot, upper;
  logic        dot_push, dot_pop, fifo_full, fifo_empty;
  entry_t      push_entry, head;
  logic [13:0] gen_q, gen_d;
  logic        ovf_q, ovf_d;

  assign addr_w = 32'(proc_addr);

`ifdef MMIO_HUB_RNG_EN
  logic [31:0] lfsr_q;
  assign sel_rng = (addr_w == 32'(RNG_ADDR));

  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_step(lfsr_q);
  end
`else
  assign sel_rng = 1'b0;
`endif

  assign in_dot  = (addr_w >= 32'(DOT_BASE)) && (addr_w < 32'(DOT_BASE + 2 * NUM_DOTS));
  assign upper   = (addr_w >= 32'(DOT_BASE + NUM_DOTS));
  assign sel_gen = !sel_rng && (addr_w == 32'(GEN_ADDR));
  assign sel_dot = !sel_rng && !sel_gen && in_dot;
  assign sel_ram = !sel_rng && !sel_gen && !sel_dot;

  assign ram_wren = proc_wren && sel_ram;
  assign dot_push = proc_wren && sel_dot;
  assign dot_pop  = dot_valid && dot_ready;

  always_comb begin
    push_entry.is_y = upper;
    push_entry.id   = upper ? ID_W'(addr_w - 32'(DOT_BASE + NUM_DOTS))
                            : ID_W'(addr_w - 32'(DOT_BASE));
    push_entry.loc  = proc_wdata;
  end

  always_comb begin
    proc_rdata = ram_rdata;
    if (sel_gen) proc_rdata = DATA_W'(gen_q);
`ifdef MMIO_HUB_RNG_EN
    if (sel_rng) proc_rdata = DATA_W'(lfsr_q);
`endif
  end

  always_comb begin
    gen_d = gen_q;
    if (proc_wren && sel_gen) begin
      if (proc_wdata[31])       gen_d = '0;
      else if (gen_q == GEN_WRAP) gen_d = '0;
      else                      gen_d = gen_q + 14'd1;
    end
    ovf_d = ovf_q | (dot_push && fifo_full && !dot_pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      gen_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      gen_q <= gen_d;
      ovf_q <= ovf_d;
    end
  end

  dot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_dot_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (dot_push),
    .push_data (push_entry),
    .pop       (dot_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dot_valid = !fifo_empty;
  assign dot_is_y  = head.is_y;
  assign dot_id    = head.id;
  assign dot_loc   = head.loc;
  assign gen_count = gen_q;
  assign fifo_ovf  = ovf_q;

endmodule

// File: tb/tb_mmio_hub.sv
// Scoreboard bench for mmio_hub: directed stimulus queues expected dot entries,
// a negedge monitor pops and checks them on every handshake.
module tb_mmio_hub;
  import mmio_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] proc_addr;
  logic [31:0] proc_wdata;
  logic        proc_wren;
  logic [31:0] proc_rdata;
  logic [31:0] ram_rdata;
  logic        ram_wren;
  logic        dot_valid;
  logic        dot_ready;
  logic        dot_is_y;
  logic [8:0]  dot_id;
  logic [31:0] dot_loc;
  logic [13:0] gen_count;
  logic        fifo_ovf;

  int vectors = 0;
  int errors  = 0;
  dot_entry_t exp_q[$];

  always #5 clock = ~clock;

  assign ram_rdata = 32'hC0DE_0000 | 32'(proc_addr);

  mmio_hub dut (
    .clock      (clock),
    .reset      (reset),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_wren  (proc_wren),
    .proc_rdata (proc_rdata),
    .ram_rdata  (ram_rdata),
    .ram_wren   (ram_wren),
    .dot_valid  (dot_valid),
    .dot_ready  (dot_ready),
    .dot_is_y   (dot_is_y),
    .dot_id     (dot_id),
    .dot_loc    (dot_loc),
    .gen_count  (gen_count),
    .fifo_ovf   (fifo_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dot_entry_t mk(input logic y, input logic [8:0] id, input logic [31:0] loc);
    dot_entry_t e;
    e.is_y = y;
    e.id   = id;
    e.loc  = loc;
    return e;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'b1000_0000_0010_0000_0000_0000_0000_0011;
    return n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [11:0] a, input logic [31:0] d);
    proc_addr  = a;
    proc_wdata = d;
    proc_wren  = 1'b1;
    tick();
    proc_wren  = 1'b0;
  endtask

  task automatic drain();
    dot_ready = 1'b1;
    for (int i = 0; i < 40 && (dot_valid || exp_q.size() > 0); i++) tick();
    chk("drain_valid", 64'(dot_valid), 64'd0);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    dot_ready = 1'b0;
  endtask

  // Monitor: every handshake must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && dot_valid && dot_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 64'(dot_id), 64'h1_0000);
        end else begin
          dot_entry_t e;
          e = exp_q.pop_front();
          chk("pop_is_y", 64'(dot_is_y), 64'(e.is_y));
          chk("pop_id",   64'(dot_id),   64'(e.id));
          chk("pop_loc",  64'(dot_loc),  64'(e.loc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m;
    int bad_zero, bad_step;
    reset = 1'b0; proc_addr = '0; proc_wdata = '0; proc_wren = 1'b0; dot_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(dot_valid), 64'd0);
    chk("rst_gen",   64'(gen_count), 64'd0);
    chk("rst_ovf",   64'(fifo_ovf),  64'd0);

`ifdef MMIO_HUB_RNG_EN
    proc_addr = 12'd99;
    #1;
    chk("rng_seed", 64'(proc_rdata), 64'hACE1_0001);
    tick();
    chk("rng_step1", 64'(proc_rdata), 64'hD650_8003);
    m = 32'hD650_8003;
    bad_zero = 0; bad_step = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      m = ref_step(m);
      if (proc_rdata == 32'd0) bad_zero++;
      if (proc_rdata != m) bad_step++;
    end
    chk("rng_nonzero", 64'(bad_zero), 64'd0);
    chk("rng_seq",     64'(bad_step), 64'd0);
`else
    proc_addr = 12'd99;
    proc_wren = 1'b1;
    #1;
    chk("rng_off_rdata", 64'(proc_rdata), 64'hC0DE_0063);
    chk("rng_off_wren",  64'(ram_wren),   64'd1);
    proc_wren = 1'b0;
    m = '0; bad_zero = 0; bad_step = 0;
`endif

    // Generation counter
    proc_addr = 12'd98; proc_wdata = '0; proc_wren = 1'b1;
    #1;
    chk("gen_wren_gate", 64'(ram_wren), 64'd0);
    tick(); tick(); tick();
    proc_wren = 1'b0;
    #1;
    chk("gen_three", 64'(gen_count), 64'd3);
    chk("gen_read",  64'(proc_rdata), 64'd3);
    write(12'd98, 32'h8000_0000);
    chk("gen_clear", 64'(gen_count), 64'd0);
    proc_wdata = '0; proc_wren = 1'b1;
    repeat (9999) tick();
    proc_wren = 1'b0;
    chk("gen_9999", 64'(gen_count), 64'd9999);
    write(12'd98, 32'd0);
    chk("gen_wrap", 64'(gen_count), 64'd0);

    // Single X and Y dot writes
    proc_addr = 12'd105; proc_wdata = 32'd42; proc_wren = 1'b1;
    #1;
    chk("dot_wren_gate", 64'(ram_wren), 64'd0);
    exp_q.push_back(mk(1'b0, 9'd5, 32'd42));
    tick();
    proc_wren = 1'b0;
    chk("dotx_valid", 64'(dot_valid), 64'd1);
    chk("dotx_is_y",  64'(dot_is_y),  64'd0);
    chk("dotx_id",    64'(dot_id),    64'd5);
    chk("dotx_loc",   64'(dot_loc),   64'd42);
    exp_q.push_back(mk(1'b1, 9'd5, 32'd42));
    write(12'd555, 32'd42);
    chk("dot_hold_id", 64'(dot_id), 64'd5);
    drain();
    proc_addr = 12'd105;
    #1;
    chk("dot_read_ram", 64'(proc_rdata), 64'hC0DE_0069);

    // Overflow: 9 writes into a stalled 8-entry FIFO
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(1'b0, 9'(i), 32'h100 + 32'(i)));
      write(12'(100 + i), 32'h100 + 32'(i));
    end
    chk("full_no_ovf", 64'(fifo_ovf), 64'd0);
    write(12'd108, 32'h108);
    chk("full_ovf",     64'(fifo_ovf), 64'd1);
    chk("full_head_id", 64'(dot_id),   64'd0);
    drain();
    chk("ovf_sticky", 64'(fifo_ovf), 64'd1);

    // Reset mid-run with queued entries
    for (int i = 0; i < 7; i++) write(12'd98, 32'd0);
    chk("pre_rst_gen", 64'(gen_count), 64'd7);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b1, 9'(i), 32'h200 + 32'(i)));
      write(12'(550 + i), 32'h200 + 32'(i));
    end
    reset = 1'b0; dot_ready = 1'b1;
    tick();
    reset = 1'b1; dot_ready = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(dot_valid), 64'd0);
    chk("mid_rst_gen",   64'(gen_count), 64'd0);
    chk("mid_rst_ovf",   64'(fifo_ovf),  64'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(1'b0, 9'(10 + i), 32'h1000 + 32'(i)));
      write(12'(110 + i), 32'h1000 + 32'(i));
    end
    proc_addr = 12'd120; proc_wdata = 32'h2000; proc_wren = 1'b1; dot_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 9'd20, 32'h2000));
    tick();
    proc_wren = 1'b0;
    chk("pushpop_ovf", 64'(fifo_ovf), 64'd0);
    drain();

    // RAM pass-through
    proc_addr = 12'd1500; proc_wdata = 32'h55; proc_wren = 1'b1;
    #1;
    chk("ram_wren",  64'(ram_wren),   64'd1);
    chk("ram_rdata", 64'(proc_rdata), 64'hC0DE_05DC);
    tick();
    proc_wren = 1'b0;
    #1;
    chk("ram_wren_idle", 64'(ram_wren), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Memory-mapped I/O hub between the processor data-memory port and the board peripherals. It decodes the processor address and does four things:
- serves a free-running LFSR random number,
- keeps the generation counter shown on the 7-segment display,
- buffers dot-position writes in a FIFO toward the VGA controller,
- passes every other access to data RAM.

It is the parametrised successor of the hard-wired address decode in the top-level wrapper.

## Interface
Parameters:
- ADDR_W, 12, processor/RAM address width
- DATA_W, 32, data width
- NUM_DOTS, 450, dots per axis; X block then Y block
- DOT_BASE, 100, first dot address
- RNG_ADDR, 99, random-number read address
- GEN_ADDR, 98, generation-counter address
- FIFO_DEPTH, 8, dot FIFO entries, power of two ≥ 2

Ports:
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- proc_addr  in  ADDR_W  processor data address
- proc_wdata  in  DATA_W  processor write data
- proc_wren  in  1  processor write enable
- proc_rdata  out  DATA_W  read data returned to processor
- ram_rdata  in  DATA_W  data RAM read data
- ram_wren  out  1  gated RAM write enable
- dot_valid  out  1  FIFO head valid
- dot_ready  in  1  VGA side accepts head
- dot_is_y  out  1  head is a Y coordinate
- dot_id  out  $clog2(NUM_DOTS)  head dot index
- dot_loc  out  DATA_W  head coordinate value
- gen_count  out  14  generation count, BCD-free binary 0..9999
- fifo_ovf  out  1  sticky overflow flag

## Operation
- **Dot range.** Addresses DOT_BASE .. DOT_BASE+2·NUM_DOTS−1.
  - Lower half is X: dot_id = addr−DOT_BASE, is_y = 0.
  - Upper half is Y: dot_id = addr−DOT_BASE−NUM_DOTS, is_y = 1.
- **Decode priority:** RNG_ADDR, then GEN_ADDR, then dot range, then RAM.
- **ram_wren** = proc_wren only when the address decodes to RAM. It is 0 for RNG_ADDR, GEN_ADDR and the dot range.
- **Dot write.** Pushes {is_y, id, proc_wdata} into the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, the push is dropped and fifo_ovf is set.
  - A push and a pop in the same cycle on a full FIFO is accepted, with no overflow.
- **FIFO output.** First-word-fall-through.
  - dot_valid = not empty; dot_* always reflect the head entry.
  - The head is popped when dot_valid && dot_ready.
- **GEN_ADDR write.**
  - proc_wdata[31] = 1: gen_count ← 0.
  - Otherwise gen_count increments, wrapping 9999 → 0.
  - A GEN_ADDR read returns gen_count zero-extended.
- **RNG_ADDR read.** Returns the current LFSR state, zero-extended or truncated to DATA_W.
  - 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
  - Advances every cycle.
  - Never reaches the all-zero state.
- **Dot-range read.** Returns ram_rdata (RAM content, not the FIFO).

## Timing
- **Reset values (reset = 0 at a rising edge):**
  - FIFO empty, dot_valid = 0
  - fifo_ovf = 0, gen_count = 0
  - LFSR = 32'hACE1_0001
  - dot_is_y, dot_id and dot_loc are don't-care while dot_valid = 0
- **Reset mid-operation.** Discards all FIFO contents. No pop is reported in the reset cycle.
- **proc_rdata.** Purely combinational on proc_addr and the registered sources. There are zero added cycles, so the processor sees the same latency as RAM.
- **Push latency.** A dot write at edge N into an empty FIFO gives dot_valid = 1 with that entry after edge N.
- **FIFO handshake.**
  - The head stays stable while dot_valid && !dot_ready.
  - Occupancy is max FIFO_DEPTH.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap.
- **gen_count and fifo_ovf** update on the edge where the write is sampled.
- **fifo_ovf** clears only on reset.

## Configuration
- **MMIO_HUB_RNG_EN defined:** the LFSR is present and RNG_ADDR is decoded as above.
- **MMIO_HUB_RNG_EN not defined:**
  - No LFSR logic.
  - RNG_ADDR is ordinary RAM: reads return ram_rdata, and writes assert ram_wren.

## Structure
- **Shared package mmio_pkg:**
  - default address constants (RNG_ADDR, GEN_ADDR, DOT_BASE)
  - LFSR seed and tap mask
  - GEN_WRAP = 9999
  - dot FIFO entry typedef {is_y, id, loc}
- **Sub-module dot_fifo:** parametrised synchronous FWFT FIFO with push/pop/full/empty. The hub adds decode, counter, LFSR and overflow logic.

## Test plan
- **Reset, then read RNG_ADDR:**
  - 32'hACE1_0001 appears in the first cycle after reset.
  - The next cycle's value equals one Galois step.
  - The LFSR never reads 0 over 10k cycles.
- **GEN_ADDR writes:**
  - 3 writes of 0 → gen_count = 3.
  - Write 32'h8000_0000 → gen_count = 0.
  - Preload to 9999 via 9999 writes, then one more → gen_count = 0.
- **Dot write to addr 100+5 with data 42** (default params): next cycle dot_valid = 1, dot_is_y = 0, dot_id = 5, dot_loc = 42, ram_wren = 0. Same write to 100+450+5 → dot_is_y = 1, dot_id = 5.
- **FIFO full:**
  - Hold dot_ready = 0 and issue 9 dot writes → only 8 held, fifo_ovf = 1.
  - Release ready → 8 entries drain in order, then dot_valid = 0.
- **Full FIFO with simultaneous push and pop** (dot_ready = 1) → no overflow, order preserved.
- **Reset mid-run:**
  - With 4 entries queued and gen_count = 7, reset = 0 for one edge → dot_valid = 0, gen_count = 0, fifo_ovf = 0.
  - RAM address 500+1000 write passes through: ram_wren = 1.
